// File: rtl/t_ff_bank.sv
// Clocked bank of WIDTH T flip-flops with parallel load, up/down count modes, change pulses and a wrap flag.
// Define T_FF_BANK_TOGCNT_EN to build the saturating change-event counter; otherwise tog_cnt is tied to 0.
module t_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] toggled,
  output logic             wrap,
  output logic [CNT_W-1:0] tog_cnt
);

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] up_mask;
  logic [WIDTH-1:0] dn_mask;
  logic             wrap_next;

  // Cascaded-T chain: a bit toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    up_mask    = '0;
    dn_mask    = '0;
    up_mask[0] = 1'b1;
    dn_mask[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_mask[i] = up_mask[i-1] & q[i-1];
      dn_mask[i] = dn_mask[i-1] & ~q[i-1];
    end
  end

  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (ld) begin
      q_next = d;
    end else if (en) begin
      unique case (mode_e'(mode))
        MODE_TOGGLE: q_next = q ^ t;
        MODE_UP: begin
          if (t[0]) begin
            q_next    = q ^ up_mask;
            wrap_next = &q;
          end
        end
        MODE_DOWN: begin
          if (t[0]) begin
            q_next    = q ^ dn_mask;
            wrap_next = ~|q;
          end
        end
        default: q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      q       <= RESET_VAL;
      toggled <= '0;
      wrap    <= 1'b0;
    end else begin
      q       <= q_next;
      toggled <= q_next ^ q;
      wrap    <= wrap_next;
    end
  end

  assign qbar = ~q;

`ifdef T_FF_BANK_TOGCNT_EN
  logic [CNT_W-1:0] cnt_r;

  // Counts edges on which q actually changes, load-caused changes included; sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if ((q_next != q) && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tog_cnt = cnt_r;
`else
  assign tog_cnt = '0;
`endif

endmodule

// File: tb/tb_t_ff_bank.sv
// Directed self-checking bench for t_ff_bank: reset, toggle, enable gating, load, up/down wrap, hold, saturation.
module tb_t_ff_bank;

`ifdef T_FF_BANK_TOGCNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] t;
  logic       ld;
  logic [7:0] d;
  logic [7:0] q;
  logic [7:0] qbar;
  logic [7:0] toggled;
  logic       wrap;
  logic [7:0] tog_cnt;

  logic       rst_b;
  logic [3:0] q_b;
  logic [3:0] qbar_b;
  logic [3:0] toggled_b;
  logic       wrap_b;
  logic [1:0] tog_cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  t_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .ld(ld), .d(d),
    .q(q), .qbar(qbar), .toggled(toggled), .wrap(wrap), .tog_cnt(tog_cnt)
  );

  t_ff_bank #(.WIDTH(4), .RESET_VAL(4'h0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst_b), .en(1'b1), .mode(2'b00), .t(4'hF), .ld(1'b0), .d(4'h0),
    .q(q_b), .qbar(qbar_b), .toggled(toggled_b), .wrap(wrap_b), .tog_cnt(tog_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ecnt(input int n);
    return CNT_ON ? 8'(n) : 8'h00;
  endfunction

  task automatic chk_all(input string tag, input logic [7:0] eq, input logic [7:0] etog,
                         input logic ewrap, input int ecount);
    check({tag, ".q"}, q, eq);
    check({tag, ".toggled"}, toggled, etog);
    check({tag, ".wrap"}, wrap, ewrap);
    check({tag, ".tog_cnt"}, tog_cnt, ecnt(ecount));
  endtask

  initial begin
    rst = 1'b0; rst_b = 1'b1; en = 1'b0; mode = 2'b00; t = 8'h00; ld = 1'b0; d = 8'h00;
    #1 rst = 1'b1;
    #1;
    chk_all("reset_init", 8'hA5, 8'h00, 1'b0, 0);
    check("reset_init.qbar", qbar, 8'h5A);
    step();
    rst = 1'b0;

    // Count up from RESET_VAL, then reset mid-cycle.
    en = 1'b1; mode = 2'b01; t = 8'h01;
    step(); chk_all("cnt_a6", 8'hA6, 8'h03, 1'b0, 1);
    step(); chk_all("cnt_a7", 8'hA7, 8'h01, 1'b0, 2);
    #3 rst = 1'b1;
    #1;
    chk_all("mid_reset", 8'hA5, 8'h00, 1'b0, 0);
    check("mid_reset.qbar", qbar, 8'h5A);
    step(); chk_all("reset_hold", 8'hA5, 8'h00, 1'b0, 0);
    rst = 1'b0;

    // Toggle mode from 00.
    ld = 1'b1; d = 8'h00;
    step(); chk_all("ld_00", 8'h00, 8'hA5, 1'b0, 1);
    ld = 1'b0; en = 1'b1; mode = 2'b00; t = 8'h0F;
    step(); chk_all("tog_0f", 8'h0F, 8'h0F, 1'b0, 2);
    check("tog_0f.qbar", qbar, 8'hF0);
    t = 8'hFF;
    step(); chk_all("tog_ff", 8'hF0, 8'hFF, 1'b0, 3);
    t = 8'h00;
    step(); chk_all("tog_00", 8'hF0, 8'h00, 1'b0, 3);

    // Enable gating, then load with en low.
    en = 1'b0; t = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step(); chk_all($sformatf("en_off%0d", i), 8'hF0, 8'h00, 1'b0, 3);
    end
    ld = 1'b1; d = 8'h3C;
    step(); chk_all("ld_3c", 8'h3C, 8'hCC, 1'b0, 4);

    // Up-count across the wrap.
    d = 8'hFE;
    step(); chk_all("ld_fe", 8'hFE, 8'hC2, 1'b0, 5);
    ld = 1'b0; en = 1'b1; mode = 2'b01; t = 8'h01;
    step(); chk_all("up_ff", 8'hFF, 8'h01, 1'b0, 6);
    step(); chk_all("up_wrap", 8'h00, 8'hFF, 1'b1, 7);
    step(); chk_all("up_01", 8'h01, 8'h01, 1'b0, 8);
    t = 8'hFE;
    step(); chk_all("up_nostrobe", 8'h01, 8'h00, 1'b0, 8);

    // Down-count across the wrap, then load priority over counting.
    mode = 2'b10; t = 8'h01;
    step(); chk_all("dn_00", 8'h00, 8'h01, 1'b0, 9);
    step(); chk_all("dn_wrap", 8'hFF, 8'hFF, 1'b1, 10);
    ld = 1'b1; d = 8'h00;
    step(); chk_all("ld_over_dn", 8'h00, 8'hFF, 1'b0, 11);
    step(); chk_all("ld_at_zero", 8'h00, 8'h00, 1'b0, 11);

    // Hold mode with everything else active.
    ld = 1'b0; mode = 2'b11; t = 8'hFF;
    step(); chk_all("hold", 8'h00, 8'h00, 1'b0, 11);

    // Saturation of a 2-bit counter on a second instance.
    rst_b = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("sat%0d.tog_cnt", i), tog_cnt_b, CNT_ON ? ((i > 3) ? 3 : i) : 0);
      check($sformatf("sat%0d.q", i), q_b, (i % 2) ? 4'hF : 4'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
